// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register sentinel, status codes
// and the pipeline-control FSM state type.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard terms for the Y86-64 pipe: load/use, return,
// branch mispredict and memory/writeback exception flags.
module pipe_hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] i_D_icode,
  input  logic [3:0] i_d_srcA,
  input  logic [3:0] i_d_srcB,
  input  logic [3:0] i_E_icode,
  input  logic [3:0] i_E_dstM,
  input  logic       i_e_Cnd,
  input  logic [3:0] i_M_icode,
  input  logic [1:0] i_m_stat,
  input  logic [1:0] i_W_stat,
  output logic       o_load_use,
  output logic       o_ret_hz,
  output logic       o_mispred,
  output logic       o_exc_m,
  output logic       o_exc_w
);

  logic w_e_is_load;

  assign w_e_is_load = (i_E_icode == I_MRMOVQ) || (i_E_icode == I_POPQ);
  assign o_load_use  = w_e_is_load && (i_E_dstM != REG_NONE) &&
                       ((i_E_dstM == i_d_srcA) || (i_E_dstM == i_d_srcB));
  assign o_ret_hz    = (i_D_icode == I_RET) || (i_E_icode == I_RET) ||
                       (i_M_icode == I_RET);
  assign o_mispred   = (i_E_icode == I_JXX) && !i_e_Cnd;
  assign o_exc_m     = (i_m_stat != STAT_AOK);
  assign o_exc_w     = (i_W_stat != STAT_AOK);

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble/set_cc generation, exception drain/halt
// sequencing, the F-stage predicted-PC register and a saturating fetch-stall counter.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned      PC_W     = 64,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter int unsigned      CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  f_predPC,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  output logic [PC_W-1:0]  F_predPC,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_state_e      r_state;
  ctrl_state_e      w_next_state;
  logic [PC_W-1:0]  r_predPC;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_load_use;
  logic             w_ret_hz;
  logic             w_mispred;
  logic             w_exc_m;
  logic             w_exc_w;
  logic             w_cnt_en;

  pipe_hazard_detect u_hazard (
    .i_D_icode  (D_icode),
    .i_d_srcA   (d_srcA),
    .i_d_srcB   (d_srcB),
    .i_E_icode  (E_icode),
    .i_E_dstM   (E_dstM),
    .i_e_Cnd    (e_Cnd),
    .i_M_icode  (M_icode),
    .i_m_stat   (m_stat),
    .i_W_stat   (W_stat),
    .o_load_use (w_load_use),
    .o_ret_hz   (w_ret_hz),
    .o_mispred  (w_mispred),
    .o_exc_m    (w_exc_m),
    .o_exc_w    (w_exc_w)
  );

  always_comb begin
    w_next_state = r_state;
    F_stall      = 1'b0;
    D_stall      = 1'b0;
    D_bubble     = 1'b0;
    E_bubble     = 1'b0;
    M_bubble     = 1'b0;
    W_stall      = 1'b0;
    set_cc       = 1'b0;
    halted       = 1'b0;
    w_cnt_en     = 1'b0;
    if (rst) begin
      D_bubble     = 1'b1;
      E_bubble     = 1'b1;
      M_bubble     = 1'b1;
      w_next_state = ST_RUN;
    end else begin
      unique case (r_state)
        ST_RUN, ST_DRAIN: begin
          F_stall  = w_load_use | w_ret_hz;
          D_stall  = w_load_use;
          // stall has priority over bubble on D
          D_bubble = (w_mispred | w_ret_hz) & ~w_load_use;
          E_bubble = w_mispred | w_load_use;
          M_bubble = w_exc_m | w_exc_w | (r_state == ST_DRAIN);
          W_stall  = w_exc_w;
          set_cc   = (E_icode == I_OPQ) & ~w_exc_m & ~w_exc_w & (r_state == ST_RUN);
          w_cnt_en = F_stall;
          if (w_exc_w)
            w_next_state = ST_HALTED;
          else if (w_exc_m && r_state == ST_RUN)
            w_next_state = ST_DRAIN;
        end
        ST_HALTED: begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          W_stall  = 1'b1;
          M_bubble = 1'b1;
          halted   = 1'b1;
        end
        default: w_next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_predPC    <= RESET_PC;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (!F_stall)
        r_predPC <= f_predPC;
      if (w_cnt_en && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign F_predPC  = r_predPC;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes model expectations each cycle,
// a negedge monitor pops and compares. A second instance with a 3-bit counter checks saturation.
module tb_pipe_ctrl;

  localparam logic [63:0] RPC  = 64'h0;
  localparam logic [63:0] RPC2 = 64'h40;
  localparam int MODE_RUN = 0, MODE_DRAIN = 1, MODE_HALT = 2;

  typedef struct {
    logic [7:0]  ctl;   // F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc,halted
    logic [63:0] pc;
    logic [31:0] cnt;
    logic [63:0] pc2;
    logic [2:0]  cnt2;
  } exp_t;

  logic clk = 0;
  logic rst;
  logic [63:0] f_predPC;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic e_Cnd;
  logic [1:0] m_stat, W_stat;
  logic [63:0] F_predPC;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [31:0] stall_cnt;
  logic [63:0] s_F_predPC;
  logic s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_set_cc, s_halted;
  logic [2:0] s_stall_cnt;

  exp_t q[$];
  int tests = 0, fails = 0;

  // model state
  logic [63:0] m_pc, m_pc2;
  longint unsigned m_cnt;
  int unsigned m_cnt2;
  int mode;
  logic p_fstall = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl #(.PC_W(64), .RESET_PC(RPC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .f_predPC(f_predPC), .D_icode(D_icode), .d_srcA(d_srcA),
    .d_srcB(d_srcB), .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .F_predPC(F_predPC), .F_stall(F_stall),
    .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .W_stall(W_stall), .set_cc(set_cc), .halted(halted), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.PC_W(64), .RESET_PC(RPC2), .CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .f_predPC(f_predPC), .D_icode(D_icode), .d_srcA(d_srcA),
    .d_srcB(d_srcB), .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat), .F_predPC(s_F_predPC), .F_stall(s_F_stall),
    .D_stall(s_D_stall), .D_bubble(s_D_bubble), .E_bubble(s_E_bubble), .M_bubble(s_M_bubble),
    .W_stall(s_W_stall), .set_cc(s_set_cc), .halted(s_halted), .stall_cnt(s_stall_cnt)
  );

  task automatic step(input logic r, input logic [3:0] di, sa, sb, ei, edm,
                      input logic c, input logic [3:0] mi, input logic [1:0] ms, ws);
    exp_t e;
    bit lu, rh, mp, xm, xw;
    @(posedge clk);
    // advance the reference across the edge using the inputs held during the last cycle
    if (rst) begin
      m_pc = RPC; m_pc2 = RPC2; m_cnt = 0; m_cnt2 = 0; mode = MODE_RUN;
    end else begin
      if (!p_fstall) begin m_pc = f_predPC; m_pc2 = f_predPC; end
      if (mode != MODE_HALT && p_fstall) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt2 < 7) m_cnt2++;
      end
      if (mode != MODE_HALT) begin
        if (W_stat != 2'b00) mode = MODE_HALT;
        else if (m_stat != 2'b00 && mode == MODE_RUN) mode = MODE_DRAIN;
      end
    end
    #1;
    rst = r; f_predPC = {$urandom, $urandom}; D_icode = di; d_srcA = sa; d_srcB = sb;
    E_icode = ei; E_dstM = edm; e_Cnd = c; M_icode = mi; m_stat = ms; W_stat = ws;
    if (r) e.ctl = 8'b0011_1000;
    else if (mode == MODE_HALT) e.ctl = 8'b1100_1101;
    else begin
      lu = (ei == 4'd5 || ei == 4'd11) && edm != 4'd15 && (edm == sa || edm == sb);
      rh = (di == 4'd9) || (ei == 4'd9) || (mi == 4'd9);
      mp = (ei == 4'd7) && !c;
      xm = ms != 2'b00;
      xw = ws != 2'b00;
      e.ctl = {lu | rh, lu, mp | (rh & !lu), mp | lu, xm | xw | (mode == MODE_DRAIN), xw,
               (ei == 4'd6) && !xm && !xw && mode == MODE_RUN, 1'b0};
    end
    e.pc = m_pc; e.cnt = m_cnt[31:0]; e.pc2 = m_pc2; e.cnt2 = m_cnt2[2:0];
    p_fstall = e.ctl[7];
    q.push_back(e);
  endtask

  task automatic nop(input logic r);
    step(r, 4'd1, 4'd15, 4'd15, 4'd1, 4'd15, 1'b1, 4'd1, 2'b00, 2'b00);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests += 5;
      if ({F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted} !== e.ctl) begin
        fails++;
        $display("FAIL ctl @%0t: got %b exp %b (F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc,halted)",
                 $time, {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted}, e.ctl);
      end
      if (F_predPC !== e.pc) begin
        fails++; $display("FAIL F_predPC @%0t: got %h exp %h", $time, F_predPC, e.pc);
      end
      if (stall_cnt !== e.cnt) begin
        fails++; $display("FAIL stall_cnt @%0t: got %0d exp %0d", $time, stall_cnt, e.cnt);
      end
      if (s_F_predPC !== e.pc2) begin
        fails++; $display("FAIL small_F_predPC @%0t: got %h exp %h", $time, s_F_predPC, e.pc2);
      end
      if (s_stall_cnt !== e.cnt2) begin
        fails++; $display("FAIL small_stall_cnt @%0t: got %0d exp %0d", $time, s_stall_cnt, e.cnt2);
      end
    end
  end

  initial begin
    rst = 1; f_predPC = '0; D_icode = 1; d_srcA = 15; d_srcB = 15; E_icode = 1;
    E_dstM = 15; e_Cnd = 1; M_icode = 1; m_stat = 0; W_stat = 0;
    m_pc = '0; m_pc2 = '0; m_cnt = 0; m_cnt2 = 0; mode = MODE_RUN;
    nop(1); nop(1); nop(0);
    step(0, 4'd1, 4'd3, 4'd15, 4'd5, 4'd3, 1'b1, 4'd1, 2'b00, 2'b00);   // load-use
    nop(0);
    step(0, 4'd1, 4'd15, 4'd15, 4'd7, 4'd15, 1'b0, 4'd1, 2'b00, 2'b00); // mispredict
    nop(0);
    step(0, 4'd9, 4'd15, 4'd15, 4'd1, 4'd15, 1'b1, 4'd1, 2'b00, 2'b00); // ret through D/E/M
    step(0, 4'd1, 4'd15, 4'd15, 4'd9, 4'd15, 1'b1, 4'd1, 2'b00, 2'b00);
    step(0, 4'd1, 4'd15, 4'd15, 4'd1, 4'd15, 1'b1, 4'd9, 2'b00, 2'b00);
    nop(0);
    step(0, 4'd9, 4'd15, 4'd4, 4'd11, 4'd4, 1'b1, 4'd1, 2'b00, 2'b00);  // ret + load-use
    nop(0);
    step(0, 4'd1, 4'd15, 4'd15, 4'd6, 4'd15, 1'b1, 4'd1, 2'b10, 2'b00); // m_stat=ADR
    step(0, 4'd1, 4'd15, 4'd15, 4'd6, 4'd15, 1'b1, 4'd1, 2'b00, 2'b00); // DRAIN, OPQ
    step(0, 4'd1, 4'd15, 4'd15, 4'd6, 4'd15, 1'b1, 4'd1, 2'b00, 2'b10); // W_stat=ADR
    step(0, 4'd9, 4'd15, 4'd15, 4'd6, 4'd15, 1'b1, 4'd1, 2'b00, 2'b00); // HALTED
    step(0, 4'd9, 4'd3, 4'd15, 4'd5, 4'd3, 1'b0, 4'd9, 2'b00, 2'b00);
    nop(1);                                                              // reset from HALTED
    nop(0);
    for (int i = 0; i < 10; i++)                                         // saturate small counter
      step(0, 4'd9, 4'd15, 4'd15, 4'd1, 4'd15, 1'b1, 4'd1, 2'b00, 2'b00);
    nop(0);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] di, ei, mi, sa, sb, edm;
      logic [1:0] ms, ws;
      di  = ($urandom_range(0, 5) == 0) ? 4'd9 : 4'($urandom_range(0, 11));
      ei  = 4'($urandom_range(0, 11));
      mi  = ($urandom_range(0, 7) == 0) ? 4'd9 : 4'($urandom_range(0, 11));
      sa  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      sb  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      edm = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      ms  = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ws  = ($urandom_range(0, 40) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(($urandom_range(0, 59) == 0), di, sa, sb, ei, edm, 1'($urandom), mi, ms, ws);
    end
    repeat (3) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
